// File: rtl/count_connected_core_feeder.sv
// Feeder for the pipelined count-connected core: turns free-slot requests into fixed-latency
// start slots, admits one queued job per slot, aligns the starting count and tracks jobs in flight.
module count_connected_core_feeder #(
  parameter int EXTRA_DATA_WIDTH           = 10,
  parameter int DATA_IN_LATENCY            = 4,
  parameter int STARTING_CONNECT_COUNT_LAG = 3,
  parameter int CORE_RESET_CYCLES          = 64,
  parameter int INFLIGHT_WIDTH             = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [127:0]                in_graph,
  input  logic [5:0]                  in_startCount,
  input  logic [EXTRA_DATA_WIDTH-1:0] in_extra,
  output logic                        core_rst,
  input  logic                        core_request,
  output logic [127:0]                core_graphIn,
  output logic                        core_start,
  output logic [5:0]                  core_startingConnectCount,
  output logic [EXTRA_DATA_WIDTH-1:0] core_extraData,
  input  logic                        core_done,
  input  logic [5:0]                  core_connectCount,
  // Result tag from the core; named apart from the outgoing core_extraData.
  input  logic [EXTRA_DATA_WIDTH-1:0] core_doneExtraData,
  output logic                        out_valid,
  output logic [5:0]                  out_connectCount,
  output logic [EXTRA_DATA_WIDTH-1:0] out_extra,
  output logic [INFLIGHT_WIDTH-1:0]   inflight,
  output logic [INFLIGHT_WIDTH-1:0]   starved,
  output logic                        idle
);

  localparam int SLOT_STAGES = DATA_IN_LATENCY - 1;
  localparam int LAG         = STARTING_CONNECT_COUNT_LAG;
  localparam int HOLD_W      = $clog2(CORE_RESET_CYCLES + 1);

  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                run;

  logic [SLOT_STAGES-1:0] slot_p;
  logic                   slot;
  logic                   accept;
  logic                   starve;

  logic [5:0]             cnt_p [LAG+1];
  logic [LAG:0]           vld_p;

  logic [INFLIGHT_WIDTH-1:0] inflight_q;
  logic [INFLIGHT_WIDTH-1:0] starved_q;

  // The RESET cycle right after rst drops is the first of the CORE_RESET_CYCLES hold cycles.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_HOLD;
        hold_d  = HOLD_W'(CORE_RESET_CYCLES - 1);
      end
      ST_HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = ST_RUN;
        else                      hold_d  = hold_q - HOLD_W'(1);
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign run      = (state_q == ST_RUN);
  assign core_rst = ~run;

  // Slot pipe: request -> slot after DATA_IN_LATENCY-1 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_p <= '0;
    end else begin
      slot_p[0] <= core_request & run;
      for (int i = 1; i < SLOT_STAGES; i++) slot_p[i] <= slot_p[i-1];
    end
  end

  assign slot     = slot_p[SLOT_STAGES-1];
  assign in_ready = slot;
  assign accept   = slot & in_valid & ~rst;
  assign starve   = slot & ~in_valid & ~rst;

  // Start stage: accepted job presented to the core
  always_ff @(posedge clk) begin
    if (rst) core_start <= 1'b0;
    else     core_start <= accept;
  end

  always_ff @(posedge clk) begin
    core_graphIn   <= accept ? in_graph : '0;
    core_extraData <= accept ? in_extra : '0;
  end

  // Count pipe: stage 0 aligns with core_start, stage LAG drives the core
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i <= LAG; i++) cnt_p[i] <= '0;
    end else begin
      vld_p[0] <= accept;
      cnt_p[0] <= accept ? in_startCount : 6'd0;
      for (int i = 1; i <= LAG; i++) begin
        vld_p[i] <= vld_p[i-1];
        cnt_p[i] <= cnt_p[i-1];
      end
    end
  end

  assign core_startingConnectCount = cnt_p[LAG];

  // Counters saturate in both directions rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      starved_q  <= '0;
    end else begin
      unique case ({core_start, core_done})
        2'b10:   if (inflight_q != '1) inflight_q <= inflight_q + INFLIGHT_WIDTH'(1);
        2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - INFLIGHT_WIDTH'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (starve && starved_q != '1) starved_q <= starved_q + INFLIGHT_WIDTH'(1);
    end
  end

  assign inflight = inflight_q;
  assign starved  = starved_q;

  // Result stage: core result registered once toward the collector
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= core_done;
  end

  always_ff @(posedge clk) begin
    out_connectCount <= rst ? 6'd0 : core_connectCount;
    out_extra        <= rst ? '0   : core_doneExtraData;
  end

  assign idle = run && (slot_p == '0) && !core_start && (vld_p == '0) && (inflight_q == '0);

endmodule

// File: tb/tb_count_connected_core_feeder.sv
// Scoreboard bench for count_connected_core_feeder: a per-cycle stimulus model queues expected
// starts, counts and results; a separate monitor pops and compares against the DUT outputs.
module tb_count_connected_core_feeder;
  localparam int EW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, in_ready;
  logic [127:0]   in_graph;
  logic [5:0]     in_startCount;
  logic [EW-1:0]  in_extra;
  logic           core_rst, core_request, core_start;
  logic [127:0]   core_graphIn;
  logic [5:0]     core_startingConnectCount;
  logic [EW-1:0]  core_extraData;
  logic           core_done;
  logic [5:0]     core_connectCount;
  logic [EW-1:0]  core_doneExtraData;
  logic           out_valid;
  logic [5:0]     out_connectCount;
  logic [EW-1:0]  out_extra;
  logic [7:0]     inflight, starved;
  logic           idle;

  count_connected_core_feeder #(
    .EXTRA_DATA_WIDTH(EW), .DATA_IN_LATENCY(4), .STARTING_CONNECT_COUNT_LAG(3),
    .CORE_RESET_CYCLES(64), .INFLIGHT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_graph(in_graph),
    .in_startCount(in_startCount), .in_extra(in_extra), .core_rst(core_rst),
    .core_request(core_request), .core_graphIn(core_graphIn), .core_start(core_start),
    .core_startingConnectCount(core_startingConnectCount), .core_extraData(core_extraData),
    .core_done(core_done), .core_connectCount(core_connectCount),
    .core_doneExtraData(core_doneExtraData), .out_valid(out_valid),
    .out_connectCount(out_connectCount), .out_extra(out_extra), .inflight(inflight),
    .starved(starved), .idle(idle)
  );

  typedef struct { logic [127:0] graph; logic [5:0] sc; logic [EW-1:0] extra; } job_t;
  typedef struct { int cyc; logic [127:0] graph; logic [EW-1:0] extra; logic [5:0] sc; } start_t;
  typedef struct { int cyc; logic [5:0] v; } cnt_t;
  typedef struct { int cyc; logic [5:0] cc; logic [EW-1:0] ex; } res_t;

  job_t   jobq[$];
  int     slotq[$];
  start_t startq[$];
  cnt_t   cntq[$];
  res_t   resq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int run_at = 0;
  int exp_starved = 0, exp_inflight = 0;
  bit mon_en = 0, rst_done = 0;
  bit m_es, m_ec, m_eo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus the stimulus-side model (slots, admission, starvation).
  task automatic step(input logic r, input logic req, input logic dn,
                      input logic [5:0] dcc, input logic [EW-1:0] dex);
    logic slot_now;
    @(negedge clk);
    if (rst_done) mon_en = 1;
    if (mon_en) begin
      chk("core_rst", core_rst, (cyc < run_at));
      chk("starved", starved, exp_starved);
    end
    rst = r; core_request = req; core_done = dn;
    core_connectCount = dcc; core_doneExtraData = dex;
    if (dn && !r) resq.push_back('{cyc + 1, dcc, dex});
    slot_now = (slotq.size() > 0) && (slotq[0] == cyc);
    if (slot_now) void'(slotq.pop_front());
    in_valid = (jobq.size() > 0);
    if (in_valid) begin
      in_graph = jobq[0].graph; in_startCount = jobq[0].sc; in_extra = jobq[0].extra;
    end else begin
      in_graph = '0; in_startCount = '0; in_extra = '0;
    end
    if (mon_en) chk("in_ready", in_ready, slot_now);
    if (r) begin
      slotq.delete();
      exp_starved = 0;
      run_at = cyc + 65;
      rst_done = 1;
    end else begin
      if (slot_now) begin
        if (in_valid) begin
          startq.push_back('{cyc + 1, in_graph, in_extra, in_startCount});
          void'(jobq.pop_front());
        end else if (exp_starved < 255) begin
          exp_starved++;
        end
      end
      if (req && cyc >= run_at) slotq.push_back(cyc + 3);
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 6'd0, '0);
  endtask

  // Monitor: compares core-side and collector-side outputs against the queued expectations.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      m_es = (startq.size() > 0) && (startq[0].cyc == cyc);
      chk("core_start", core_start, m_es);
      if (m_es) begin
        chk("core_graphIn", core_graphIn, startq[0].graph);
        chk("core_extraData", core_extraData, startq[0].extra);
        cntq.push_back('{cyc + 3, startq[0].sc});
        void'(startq.pop_front());
      end else begin
        chk("core_graphIn_idle", core_graphIn, 128'd0);
        chk("core_extraData_idle", core_extraData, 0);
      end
      m_ec = (cntq.size() > 0) && (cntq[0].cyc == cyc);
      if (m_ec) begin
        chk("core_startingConnectCount", core_startingConnectCount, cntq[0].v);
        void'(cntq.pop_front());
      end else begin
        chk("core_startingConnectCount_idle", core_startingConnectCount, 0);
      end
      m_eo = (resq.size() > 0) && (resq[0].cyc == cyc);
      chk("out_valid", out_valid, m_eo);
      if (m_eo) begin
        chk("out_connectCount", out_connectCount, resq[0].cc);
        chk("out_extra", out_extra, resq[0].ex);
        void'(resq.pop_front());
      end
      chk("inflight", inflight, exp_inflight);
      if (rst) exp_inflight = 0;
      else if (m_es && !core_done && exp_inflight < 255) exp_inflight++;
      else if (!m_es && core_done && exp_inflight > 0) exp_inflight--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; core_request = 0; core_done = 0; core_connectCount = 0; core_doneExtraData = 0;
    in_valid = 0; in_graph = 0; in_startCount = 0; in_extra = 0;

    // Reset stretch: 64 cycles of core_rst after rst drops, then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (64) idle_step();
    chk("idle_in_hold", idle, 1'b0);
    idle_step();
    chk("idle_after_hold", idle, 1'b1);

    // Single job: ready at t+3, start at t+4, count at t+7
    jobq.push_back('{128'h1, 6'd5, 10'd3});
    step(0, 1, 0, 0, 0);
    repeat (8) idle_step();
    chk("inflight_one", inflight, 8'd1);

    // Back-to-back requests with four queued jobs
    jobq.push_back('{128'hDEAD_BEEF_0000_0000_0000_0000_0000_0011, 6'd10, 10'h155});
    jobq.push_back('{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 6'd63, 10'h2AA});
    jobq.push_back('{{4{32'hA5A5_5A5A}}, 6'd0, 10'h3FF});
    jobq.push_back('{128'h8000_0000_0000_0000_0000_0000_0000_0001, 6'd33, 10'h001});
    repeat (4) step(0, 1, 0, 0, 0);
    repeat (8) idle_step();
    chk("inflight_five", inflight, 8'd5);

    // Slot with no job: starved counts, nothing starts
    step(0, 1, 0, 0, 0);
    repeat (6) idle_step();
    chk("starved_one", starved, 8'd1);

    // Results drain inflight to 2, then start and done coincide
    step(0, 0, 1, 6'd7, 10'h011);
    step(0, 0, 1, 6'd0, 10'h3FF);
    step(0, 0, 1, 6'd63, 10'h200);
    jobq.push_back('{128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 6'd17, 10'h0AB});
    step(0, 1, 0, 0, 0);
    repeat (3) idle_step();
    step(0, 0, 1, 6'd21, 10'h123);
    repeat (3) idle_step();
    chk("inflight_unchanged", inflight, 8'd2);
    step(0, 0, 1, 6'd1, 10'h002);
    step(0, 0, 1, 6'd2, 10'h004);
    step(0, 0, 1, 6'd3, 10'h008);
    repeat (6) idle_step();
    chk("inflight_floor", inflight, 8'd0);
    chk("idle_drained", idle, 1'b1);

    // rst during HOLD with a request pending: nothing starts, hold restarts in full
    step(1, 0, 0, 0, 0);
    repeat (4) idle_step();
    jobq.push_back('{128'h77, 6'd9, 10'h077});
    step(0, 1, 0, 0, 0);
    idle_step();
    step(1, 0, 0, 0, 0);
    repeat (64) idle_step();
    chk("idle_rehold", idle, 1'b0);
    repeat (6) idle_step();
    chk("no_start_after_rehold", inflight, 8'd0);
    jobq.delete();
    idle_step();

    // Starved counter saturation
    repeat (260) step(0, 1, 0, 0, 0);
    repeat (5) idle_step();
    chk("starved_saturated", starved, 8'hFF);

    chk("startq_drained", startq.size(), 0);
    chk("cntq_drained", cntq.size(), 0);
    chk("resq_drained", resq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
